// File: rtl/scoreboard_register_file.sv
// Scalar/vector register file with a per-register busy scoreboard and an FSM that clears every register in turn.
// Latency: reads and bypass are combinational. Writes, reservations and clear steps take effect at the next rising clk.
// Backpressure: ISS_READY falls and writes are dropped for the NS+NV cycles of a bulk clear. Reads stay live throughout.
module scoreboard_register_file #(
    parameter int N  = 32,
    parameter int I  = 20,
    parameter int L  = 8,
    parameter int NS = 16,
    parameter int NV = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           WE,
    input  logic [4:0]     A3_WB,
    input  logic [I-1:0]   WM,
    input  logic [N-1:0]   WD3_SCA,
    input  logic [I*L-1:0] WD3_VEC,
    input  logic [4:0]     A1,
    input  logic [4:0]     A2,
    output logic [N-1:0]   RD1_SCA,
    output logic [N-1:0]   RD2_SCA,
    output logic [I*L-1:0] RD1_VEC,
    output logic [I*L-1:0] RD2_VEC,
    output logic           BUSY1,
    output logic           BUSY2,
    input  logic           ISS_VALID,
    input  logic [4:0]     ISS_RD,
    output logic           ISS_READY,
    input  logic           CLR_REQ,
    output logic           CLR_BUSY,
    output logic           CLR_DONE
);

    localparam int NR = NS + NV;
    localparam int SW = (NS > 1) ? $clog2(NS) : 1;
    localparam int VW = (NV > 1) ? $clog2(NV) : 1;
    localparam logic [5:0] NS6  = 6'(NS);
    localparam logic [5:0] NR6  = 6'(NR);
    localparam logic [4:0] LAST = 5'(NR - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t         state;
    logic [4:0]     cnt;
    logic           clr_busy_q;
    logic           clr_done_q;

    logic [N-1:0]   sca_q [NS];
    logic [I*L-1:0] vec_q [NV];
    logic [NR-1:0]  busy_q;

    logic           wr_en;
    logic [I*L-1:0] vec_old;
    logic [I*L-1:0] vec_merged;

    function automatic logic is_sca(input logic [4:0] a);
        return {1'b0, a} < NS6;
    endfunction

    function automatic logic is_map(input logic [4:0] a);
        return {1'b0, a} < NR6;
    endfunction

    function automatic logic is_vec(input logic [4:0] a);
        return is_map(a) && !is_sca(a);
    endfunction

    function automatic logic [SW-1:0] sidx(input logic [4:0] a);
        return SW'(a);
    endfunction

    function automatic logic [VW-1:0] vidx(input logic [4:0] a);
        return VW'({1'b0, a} - NS6);
    endfunction

    assign wr_en     = WE && !clr_busy_q && is_map(A3_WB);
    assign CLR_BUSY  = clr_busy_q;
    assign CLR_DONE  = clr_done_q;
    assign ISS_READY = !clr_busy_q;

    // Post-write vector value, shared by the commit path and the read bypass.
    always_comb begin
        vec_old    = is_vec(A3_WB) ? vec_q[vidx(A3_WB)] : '0;
        vec_merged = vec_old;
        for (int k = 0; k < I; k++) begin
            if (WM[k]) vec_merged[k*L +: L] = WD3_VEC[k*L +: L];
        end
    end

    always_comb begin
        RD1_SCA = '0;
        RD2_SCA = '0;
        RD1_VEC = '0;
        RD2_VEC = '0;
        BUSY1   = 1'b0;
        BUSY2   = 1'b0;
        if (is_sca(A1)) RD1_SCA = (wr_en && A1 == A3_WB) ? WD3_SCA : sca_q[sidx(A1)];
        if (is_sca(A2)) RD2_SCA = (wr_en && A2 == A3_WB) ? WD3_SCA : sca_q[sidx(A2)];
        if (is_vec(A1)) RD1_VEC = (wr_en && A1 == A3_WB) ? vec_merged : vec_q[vidx(A1)];
        if (is_vec(A2)) RD2_VEC = (wr_en && A2 == A3_WB) ? vec_merged : vec_q[vidx(A2)];
        // Busy is the stored reservation only; an in-flight write does not bypass it.
        if (is_map(A1)) BUSY1 = busy_q[A1];
        if (is_map(A2)) BUSY2 = busy_q[A2];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NS; s++) sca_q[s] <= '0;
            for (int v = 0; v < NV; v++) vec_q[v] <= '0;
        end else if (clr_busy_q) begin
            if (is_sca(cnt))      sca_q[sidx(cnt)] <= '0;
            else if (is_vec(cnt)) vec_q[vidx(cnt)] <= '0;
        end else if (wr_en) begin
            if (is_sca(A3_WB)) sca_q[sidx(A3_WB)] <= WD3_SCA;
            else               vec_q[vidx(A3_WB)] <= vec_merged;
        end
    end

    // Issue is applied after write-back so a same-cycle reservation survives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else if (state == IDLE && CLR_REQ) begin
            busy_q <= '0;
        end else begin
            if (wr_en) busy_q[A3_WB] <= 1'b0;
            if (ISS_VALID && !clr_busy_q && is_map(ISS_RD)) busy_q[ISS_RD] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clr_done_q <= 1'b0;
                    if (CLR_REQ) begin
                        state      <= CLEAR;
                        cnt        <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST) begin
                        state      <= DONE;
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    clr_done_q <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    clr_busy_q <= 1'b0;
                    clr_done_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Directed and randomized checks of scoreboard_register_file against a lane-array model of the register file.
module tb_scoreboard_register_file;

    logic         clk, rst;
    logic         WE, ISS_VALID, CLR_REQ;
    logic [4:0]   A3_WB, A1, A2, ISS_RD;
    logic [19:0]  WM;
    logic [31:0]  WD3_SCA;
    logic [159:0] WD3_VEC;
    logic [31:0]  RD1_SCA, RD2_SCA;
    logic [159:0] RD1_VEC, RD2_VEC;
    logic         BUSY1, BUSY2, ISS_READY, CLR_BUSY, CLR_DONE;

    int n_pass   = 0;
    int n_checks = 0;

    logic [31:0] m_sca [16];
    logic [7:0]  m_vec [8][20];
    bit          m_busy[24];

    scoreboard_register_file dut (
        .clk(clk), .rst(rst), .WE(WE), .A3_WB(A3_WB), .WM(WM),
        .WD3_SCA(WD3_SCA), .WD3_VEC(WD3_VEC), .A1(A1), .A2(A2),
        .RD1_SCA(RD1_SCA), .RD2_SCA(RD2_SCA), .RD1_VEC(RD1_VEC), .RD2_VEC(RD2_VEC),
        .BUSY1(BUSY1), .BUSY2(BUSY2), .ISS_VALID(ISS_VALID), .ISS_RD(ISS_RD),
        .ISS_READY(ISS_READY), .CLR_REQ(CLR_REQ), .CLR_BUSY(CLR_BUSY), .CLR_DONE(CLR_DONE)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int r = 0; r < 16; r++) m_sca[r] = '0;
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 20; k++) m_vec[r][k] = '0;
        for (int r = 0; r < 24; r++) m_busy[r] = 1'b0;
    endtask

    task automatic model_zero(input int r);
        if (r < 16) m_sca[r] = '0;
        else for (int k = 0; k < 20; k++) m_vec[r-16][k] = '0;
    endtask

    function automatic logic [31:0] m_rd_sca(input int a);
        return (a < 16) ? m_sca[a] : 32'h0;
    endfunction

    function automatic logic [159:0] m_rd_vec(input int a);
        logic [159:0] v = '0;
        if (a >= 16 && a < 24)
            for (int k = 0; k < 20; k++) v[k*8 +: 8] = m_vec[a-16][k];
        return v;
    endfunction

    function automatic logic m_rd_busy(input int a);
        return (a < 24) ? m_busy[a] : 1'b0;
    endfunction

    function automatic logic [159:0] rand_vec();
        logic [159:0] v;
        for (int j = 0; j < 5; j++) v[j*32 +: 32] = $urandom;
        return v;
    endfunction

    // A committed write is visible on the read ports within its own cycle,
    // so the model takes the write before the combinational sample.
    task automatic model_write();
        if (WE && A3_WB < 24) begin
            if (A3_WB < 16) m_sca[A3_WB] = WD3_SCA;
            else
                for (int k = 0; k < 20; k++)
                    if (WM[k]) m_vec[A3_WB-16][k] = WD3_VEC[k*8 +: 8];
        end
    endtask

    task automatic check_reads();
        chk("rd1_sca", RD1_SCA, m_rd_sca(A1));
        chk("rd2_sca", RD2_SCA, m_rd_sca(A2));
        chk("rd1_vec", RD1_VEC, m_rd_vec(A1));
        chk("rd2_vec", RD2_VEC, m_rd_vec(A2));
        chk("busy1", BUSY1, m_rd_busy(A1));
        chk("busy2", BUSY2, m_rd_busy(A2));
    endtask

    task automatic cycle();
        model_write();
        @(negedge clk);
        check_reads();
        chk("iss_ready", ISS_READY, 1);
        @(posedge clk);
        if (WE && A3_WB < 24) m_busy[A3_WB] = 1'b0;
        if (ISS_VALID && ISS_RD < 24) m_busy[ISS_RD] = 1'b1;
        if (CLR_REQ) for (int r = 0; r < 24; r++) m_busy[r] = 1'b0;
        #1;
    endtask

    task automatic clear_iter(input int k);
        A1 = 5'(k);
        A2 = 5'((k + 23) % 24);
        WE = 1'b1;
        A3_WB = 5'(k);
        WM = '1;
        WD3_SCA = $urandom;
        WD3_VEC = rand_vec();
        ISS_VALID = 1'b1;
        ISS_RD = 5'($urandom_range(0, 23));
        @(negedge clk);
        check_reads();
        chk("clr_busy_in_clear", CLR_BUSY, 1);
        chk("iss_ready_in_clear", ISS_READY, 0);
        chk("clr_done_in_clear", CLR_DONE, 0);
        @(posedge clk);
        model_zero(k);
        #1;
    endtask

    task automatic fill_all();
        ISS_VALID = 1'b0;
        CLR_REQ = 1'b0;
        for (int a = 0; a < 24; a++) begin
            WE = 1'b1;
            A3_WB = 5'(a);
            WM = '1;
            WD3_SCA = $urandom | 32'h1;
            WD3_VEC = rand_vec() | {20{8'h01}};
            A1 = 5'(a);
            A2 = 5'($urandom_range(0, 31));
            cycle();
        end
        WE = 1'b0;
    endtask

    initial begin
        logic [159:0] exp_vec;
        int done_seen;

        rst = 1'b1;
        WE = 0; ISS_VALID = 0; CLR_REQ = 0;
        A3_WB = 0; A1 = 5'd3; A2 = 5'd17; ISS_RD = 0; WM = 0;
        WD3_SCA = 0; WD3_VEC = 0;
        model_reset();
        #3 rst = 1'b0;
        #1;
        chk("rst_clr_busy", CLR_BUSY, 0);
        chk("rst_clr_done", CLR_DONE, 0);
        chk("rst_iss_ready", ISS_READY, 1);
        check_reads();
        @(posedge clk);
        #1 rst = 1'b1;

        // Bypassed scalar write, then the stored value after the edge.
        WE = 1; A3_WB = 5'd3; WD3_SCA = 32'hDEADBEEF; A1 = 5'd3; A2 = 5'd0;
        cycle();
        WE = 0;
        @(negedge clk);
        chk("sca3_after_edge", RD1_SCA, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Masked vector write into register 17.
        WE = 1; A3_WB = 5'd17; WM = '1; WD3_VEC = {20{8'h11}}; A2 = 5'd17;
        cycle();
        WM = 20'h00005; WD3_VEC = {20{8'hFF}};
        cycle();
        WE = 0;
        for (int k = 0; k < 20; k++) exp_vec[k*8 +: 8] = (k == 0 || k == 2) ? 8'hFF : 8'h11;
        @(negedge clk);
        chk("vec17_masked", RD2_VEC, exp_vec);
        @(posedge clk); #1;

        // Reservation, release, and same-cycle issue-plus-write on register 18.
        A1 = 5'd18; ISS_VALID = 1; ISS_RD = 5'd18;
        cycle();
        ISS_VALID = 0;
        @(negedge clk); chk("busy18_set", BUSY1, 1); @(posedge clk); #1;
        WE = 1; A3_WB = 5'd18; WM = '1; WD3_VEC = rand_vec();
        cycle();
        WE = 0;
        @(negedge clk); chk("busy18_cleared", BUSY1, 0); @(posedge clk); #1;
        WE = 1; ISS_VALID = 1; ISS_RD = 5'd18;
        cycle();
        WE = 0; ISS_VALID = 0;
        @(negedge clk); chk("busy18_issue_wins", BUSY1, 1); @(posedge clk); #1;

        // Unmapped write and issue at address 30.
        ISS_VALID = 1; ISS_RD = 5'd30;
        cycle();
        ISS_VALID = 0;
        WE = 1; A3_WB = 5'd30; WD3_SCA = 32'hFFFFFFFF; WD3_VEC = '1; WM = '1; A1 = 5'd30;
        @(negedge clk);
        chk("unmapped_sca", RD1_SCA, 0);
        chk("unmapped_vec", RD1_VEC, 0);
        chk("unmapped_busy", BUSY1, 0);
        @(posedge clk); #1;
        WE = 0;

        for (int n = 0; n < 300; n++) begin
            WE = 1'($urandom);
            A3_WB = 5'($urandom);
            WM = 20'($urandom);
            WD3_SCA = $urandom;
            WD3_VEC = rand_vec();
            A1 = ($urandom_range(0, 3) == 0) ? A3_WB : 5'($urandom);
            A2 = 5'($urandom);
            ISS_VALID = 1'($urandom);
            ISS_RD = 5'($urandom);
            cycle();
        end

        // Bulk clear with a write in the request cycle.
        fill_all();
        WE = 1; A3_WB = 5'd5; WD3_SCA = 32'hA5A5A5A5; A1 = 5'd5; CLR_REQ = 1; ISS_VALID = 0;
        cycle();
        CLR_REQ = 0;
        for (int k = 0; k < 24; k++) clear_iter(k);
        WE = 0; ISS_VALID = 0; CLR_REQ = 1;
        @(negedge clk);
        chk("done_pulse", CLR_DONE, 1);
        chk("done_clr_busy", CLR_BUSY, 0);
        chk("done_iss_ready", ISS_READY, 1);
        @(posedge clk); #1;
        CLR_REQ = 0;
        @(negedge clk);
        chk("done_one_cycle", CLR_DONE, 0);
        chk("req_ignored_in_done", CLR_BUSY, 0);
        @(posedge clk); #1;
        for (int a = 0; a < 24; a++) begin
            A1 = 5'(a);
            A2 = 5'(23 - a);
            #1 check_reads();
        end

        // Reset arriving between edges in the middle of a clear.
        fill_all();
        CLR_REQ = 1;
        cycle();
        CLR_REQ = 0;
        for (int k = 0; k < 10; k++) clear_iter(k);
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_mid_clr_busy", CLR_BUSY, 0);
        chk("rst_mid_iss_ready", ISS_READY, 1);
        chk("rst_mid_clr_done", CLR_DONE, 0);
        WE = 0; ISS_VALID = 0;
        for (int a = 0; a < 24; a++) begin
            A1 = 5'(a);
            A2 = 5'(23 - a);
            #1 check_reads();
        end
        @(posedge clk);
        #1 rst = 1'b1;
        WE = 1; A3_WB = 5'd20; WM = 20'h80001; WD3_VEC = rand_vec(); A1 = 5'd20; A2 = 5'd3;
        cycle();
        WE = 0;
        done_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (CLR_DONE) done_seen++;
        end
        chk("no_done_after_abort", done_seen, 0);
        @(posedge clk); #1;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scoreboard_register_file.md
SCOREBOARD_REGISTER_FILE -- requirements
Module: scoreboard_register_file

Interface
REQ-001 Parameters SHALL be: N, 32, scalar width; I, 20, vector lane count; L, 8, lane width; NS, 16, scalar register count; NV, 8, vector register count; NS+NV <= 32.
REQ-002 Ports SHALL be: clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-low.
REQ-004 WE  in  1  write-back enable; A3_WB  in  5  write address; WM  in  I  vector lane write mask; WD3_SCA  in  N  scalar write data; WD3_VEC  in  I*L  vector write data (I lanes of L bits).
REQ-005 A1, A2  in  5 each  read addresses; RD1_SCA, RD2_SCA  out  N; RD1_VEC, RD2_VEC  out  I*L; BUSY1, BUSY2  out  1  pending-write flag of A1/A2.
REQ-006 ISS_VALID  in  1  issue request; ISS_RD  in  5  destination to reserve; ISS_READY  out  1  issue accepted when high.
REQ-007 CLR_REQ  in  1  start bulk clear; CLR_BUSY  out  1  clear in progress; CLR_DONE  out  1  one-cycle completion pulse.

Function
REQ-010 Address map SHALL be: 0..NS-1 scalar registers, NS..NS+NV-1 vector registers, >= NS+NV unmapped.
REQ-011 Reads SHALL be combinational; scalar outputs show the scalar register addressed (0 if address not scalar); vector outputs show the vector register addressed (0 if address not vector).
REQ-012 Writes SHALL commit at rising clk when WE=1, CLR_BUSY=0, address mapped; unmapped writes ignored.
REQ-013 Scalar write SHALL replace all N bits; WM ignored.
REQ-014 Vector write SHALL update only lanes k with WM[k]=1; other lanes hold.
REQ-015 Bypass: when WE=1, CLR_BUSY=0 and A1 (or A2) equals A3_WB, read output SHALL present post-write value (merged lanes for vectors) in the same cycle.
REQ-016 Scoreboard: one busy bit per mapped register; accepted issue (ISS_VALID & ISS_READY, ISS_RD mapped) sets bit at next edge; committed write clears it at next edge.
REQ-017 Simultaneous issue and write to same register SHALL leave the bit set (new reservation wins).
REQ-018 BUSY1/BUSY2 SHALL reflect stored bit of A1/A2 combinationally; 0 for unmapped addresses; not bypassed.
REQ-019 ISS_READY SHALL equal ~CLR_BUSY; issue to unmapped address accepted but no effect.
REQ-020 Clear FSM states: IDLE, CLEAR, DONE.
REQ-021 IDLE->CLEAR on CLR_REQ=1; all busy bits clear on that edge; counter loads 0.
REQ-022 CLEAR: zero register at counter index each cycle (all lanes), counter+1; after index NS+NV-1 go DONE; total NS+NV cycles.
REQ-023 DONE: CLR_DONE=1 for exactly one cycle, then IDLE; CLR_BUSY=1 in CLEAR only.
REQ-024 During CLEAR/DONE, CLR_REQ SHALL be ignored; WE ignored during CLEAR only; reads remain live (partially cleared contents visible).
REQ-025 CLR_REQ and WE in same IDLE cycle: write commits, then clear proceeds and later zeroes it.

Reset
REQ-030 rst=0 SHALL immediately force all registers to 0, all busy bits to 0, FSM to IDLE, counter to 0, CLR_BUSY=0, CLR_DONE=0, ISS_READY=1, independent of clk.
REQ-031 Reset mid-clear SHALL abort clear without CLR_DONE pulse.
REQ-032 After rst deassert, first rising edge SHALL be a normal operating cycle.

Verification
REQ-040 Write A3_WB=3, WD3_SCA=0xDEADBEEF, WE=1, A1=3 -> RD1_SCA=0xDEADBEEF same cycle (bypass) and after edge.
REQ-041 Vector reg 17 all lanes 0x11; write WM=0x00005, WD3_VEC all 0xFF -> lanes 0,2 =0xFF, others 0x11; RD2_VEC via A2=17 matches.
REQ-042 Issue ISS_RD=18 -> BUSY1=1 for A1=18 next cycle; WE to 18 -> BUSY1=0 after edge; issue+WE to 18 same cycle -> BUSY1 stays 1.
REQ-043 Fill regs nonzero, pulse CLR_REQ -> CLR_BUSY high 24 cycles, WE in that window ignored, CLR_DONE one cycle, all reads 0, ISS_READY 0 during CLEAR.
REQ-044 Assert rst=0 at clear cycle 10 between edges -> CLR_BUSY=0 immediately, no CLR_DONE, all regs 0.
REQ-045 WE to address 30, A1=30 -> RD1_SCA=0, RD1_VEC=0, BUSY1=0; no mapped register altered.
